decoder_cpu_oci_trace_capture: RTL

//  Parametrised capture buffer for the OCI debug compressed trace (DCT) stream.

---
 rtl/decoder_cpu_oci_trace_capture_if.sv | 36 +++
 rtl/decoder_cpu_oci_trace_capture.sv | 99 +++++++++
 2 files changed

// File: rtl/decoder_cpu_oci_trace_capture_if.sv
// Bus bundle for the DCT trace capture buffer: trace input, control levels,
// read-back port and status. The master drives the trace/control side.
interface decoder_cpu_oci_trace_capture_if #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4,
  parameter int AW     = 4
);
  localparam int FW = ATOM_W * ATOMS;

  logic [FW-1:0]       dct_buffer;
  logic [CNT_W-1:0]    dct_count;
  logic                dct_valid;
  logic                test_ending;
  logic                test_has_ended;
  logic                mode_wrap;
  logic                rd_req;
  logic [FW+CNT_W-1:0] rd_data;
  logic                rd_valid;
  logic [AW:0]         level;
  logic                overflow;
  logic                count_err;
  logic                frozen;
  logic                ended;
  logic [31:0]         total_atoms;

  modport master (
    output dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, mode_wrap, rd_req,
    input  rd_data, rd_valid, level, overflow, count_err, frozen, ended, total_atoms
  );

  modport slave (
    input  dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, mode_wrap, rd_req,
    output rd_data, rd_valid, level, overflow, count_err, frozen, ended, total_atoms
  );
endinterface

// File: rtl/decoder_cpu_oci_trace_capture.sv
// Circular capture buffer for OCI compressed trace frames with stop-on-full or
// keep-newest modes, freeze on test end, and one-frame-per-request read-back.
module decoder_cpu_oci_trace_capture #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4,
  parameter int AW     = 4
) (
  input logic clk,
  input logic reset,
  decoder_cpu_oci_trace_capture_if.slave bus
);
  localparam int FW    = ATOM_W * ATOMS;
  localparam int DW    = FW + CNT_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [CNT_W-1:0] ATOMS_C = CNT_W'(ATOMS);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {CAPTURE, FROZEN, ENDED} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level_q;
  logic [DW-1:0]    rd_data_q;
  logic             rd_valid_q, overflow_q, count_err_q;
  logic [31:0]      total_q;

  logic             full, wr_try, rd_do, clamped, store, wrap_ovw, lost;
  logic [CNT_W-1:0] cnt_c;
  logic [32:0]      total_sum;

  // A read frees a slot in the same edge, so a full buffer only loses data
  // when a write arrives without a companion read.
  always_comb begin
    full      = (level_q == DEPTH_C);
    wr_try    = bus.dct_valid && (bus.dct_count != '0) && (state_q == CAPTURE);
    rd_do     = bus.rd_req && (level_q != '0);
    clamped   = (bus.dct_count > ATOMS_C);
    cnt_c     = clamped ? ATOMS_C : bus.dct_count;
    store     = wr_try && (!full || rd_do || bus.mode_wrap);
    lost      = wr_try && full && !rd_do;
    wrap_ovw  = store && lost;
    total_sum = {1'b0, total_q} + 33'(cnt_c);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: begin
        if (bus.test_has_ended)   state_d = ENDED;
        else if (bus.test_ending) state_d = FROZEN;
      end
      FROZEN: begin
        if (bus.test_has_ended) state_d = ENDED;
      end
      default: state_d = ENDED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= {cnt_c, bus.dct_buffer};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CAPTURE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      count_err_q <= 1'b0;
      total_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_do;
      if (rd_do) rd_data_q <= mem[rd_ptr];
      if (store) wr_ptr <= wr_ptr + AW'(1);
      // A wrap overwrite discards the oldest entry, so the read side advances too.
      if (rd_do || wrap_ovw) rd_ptr <= rd_ptr + AW'(1);
      if (store && !rd_do && !full) level_q <= level_q + (AW+1)'(1);
      else if (rd_do && !store)     level_q <= level_q - (AW+1)'(1);
      if (lost) overflow_q <= 1'b1;
      if (store && clamped) count_err_q <= 1'b1;
      if (store) total_q <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.count_err   = count_err_q;
  assign bus.frozen      = (state_q != CAPTURE);
  assign bus.ended       = (state_q == ENDED);
  assign bus.total_atoms = total_q;
endmodule
